// File: rtl/alu_operand_stage.sv
// Operand/write-back stage around an external combinational ALU: latches an instruction,
// fetches operands from a small register bank, and writes the ALU result back. Optional: OPSTAGE_R0_ZERO_EN.
module alu_operand_stage #(
   parameter int DATA_LEN     = 16,
   parameter int ALU_SIG_LEN  = 3,
   parameter int REG_ADDR_LEN = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    instr_valid,
   output logic                    instr_ready,
   input  logic [ALU_SIG_LEN-1:0]  instr_op,
   input  logic [REG_ADDR_LEN-1:0] instr_ra,
   input  logic [REG_ADDR_LEN-1:0] instr_rb,
   input  logic [REG_ADDR_LEN-1:0] instr_rd,
   input  logic                    ld_en,
   input  logic [REG_ADDR_LEN-1:0] ld_addr,
   input  logic [DATA_LEN-1:0]     ld_data,
   output logic [DATA_LEN-1:0]     alu_a,
   output logic [DATA_LEN-1:0]     alu_b,
   output logic [ALU_SIG_LEN-1:0]  alu_select,
   input  logic [DATA_LEN-1:0]     alu_out,
   input  logic                    alu_z,
   output logic                    z_reg,
   output logic                    wb_done,
   output logic                    halted
);

   localparam int NUM_REGS = 2**REG_ADDR_LEN;
   localparam logic [ALU_SIG_LEN-1:0] OP_ADD  = ALU_SIG_LEN'(0);
   localparam logic [ALU_SIG_LEN-1:0] OP_SUB  = ALU_SIG_LEN'(1);
   localparam logic [ALU_SIG_LEN-1:0] OP_HALT = ALU_SIG_LEN'(6);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WRITE, S_HALT} state_t;

   state_t                  state_q, state_d;
   logic [ALU_SIG_LEN-1:0]  op_q;
   logic [REG_ADDR_LEN-1:0] ra_q, rb_q, rd_q;
   logic [DATA_LEN-1:0]     alu_a_q, alu_b_q;
   logic [ALU_SIG_LEN-1:0]  alu_sel_q;
   logic                    z_q;
   logic [DATA_LEN-1:0]     regs_q [NUM_REGS];

   logic                    accept;
   logic [DATA_LEN-1:0]     rd_a, rd_b;
   logic                    wr_en;
   logic [REG_ADDR_LEN-1:0] wr_addr;
   logic [DATA_LEN-1:0]     wr_data;

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_select = alu_sel_q;
   assign z_reg      = z_q;

   always_comb begin
      state_d     = state_q;
      instr_ready = 1'b0;
      wb_done     = 1'b0;
      halted      = 1'b0;
      accept      = 1'b0;
      case (state_q)
         S_IDLE: begin
            // a direct load takes the cycle; the instruction waits
            instr_ready = !ld_en;
            if (instr_valid && !ld_en) begin
               accept  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_FETCH: state_d = S_EXEC;
         S_EXEC:  state_d = (op_q == OP_HALT) ? S_HALT : S_WRITE;
         S_WRITE: begin
            wb_done = !reset;
            state_d = S_IDLE;
         end
         S_HALT:  halted = 1'b1;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rd_a = regs_q[ra_q];
      rd_b = regs_q[rb_q];
`ifdef OPSTAGE_R0_ZERO_EN
      if (ra_q == '0) rd_a = '0;
      if (rb_q == '0) rd_b = '0;
`endif
   end

   always_comb begin
      wr_en   = (state_q == S_WRITE) || (state_q == S_IDLE && ld_en);
      wr_addr = (state_q == S_WRITE) ? rd_q : ld_addr;
      wr_data = (state_q == S_WRITE) ? alu_out : ld_data;
`ifdef OPSTAGE_R0_ZERO_EN
      if (wr_addr == '0) wr_en = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         ra_q      <= '0;
         rb_q      <= '0;
         rd_q      <= '0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_sel_q <= '0;
         z_q       <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q <= instr_op;
            ra_q <= instr_ra;
            rb_q <= instr_rb;
            rd_q <= instr_rd;
         end
         if (state_q == S_FETCH) begin
            alu_a_q   <= rd_a;
            alu_b_q   <= rd_b;
            alu_sel_q <= op_q;
         end
         // only add/sub refresh the zero flag
         if (state_q == S_WRITE && (op_q == OP_ADD || op_q == OP_SUB)) z_q <= alu_z;
         if (wr_en) regs_q[wr_addr] <= wr_data;
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with a small behavioural ALU in the loop.
// Honours OPSTAGE_R0_ZERO_EN for the entry-0 expectation.
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic        instr_ready;
   logic [2:0]  instr_op, instr_ra, instr_rb, instr_rd;
   logic        ld_en;
   logic [2:0]  ld_addr;
   logic [15:0] ld_data;
   logic [15:0] alu_a, alu_b, alu_out;
   logic [2:0]  alu_select;
   logic        alu_z, z_reg, wb_done, halted;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_operand_stage dut (
      .clk(clk), .reset(reset),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_ra(instr_ra), .instr_rb(instr_rb), .instr_rd(instr_rd),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
      .alu_out(alu_out), .alu_z(alu_z),
      .z_reg(z_reg), .wb_done(wb_done), .halted(halted)
   );

   always_comb begin
      case (alu_select)
         3'b000:  alu_out = alu_a + alu_b;
         3'b001:  alu_out = alu_a - alu_b;
         3'b010:  alu_out = alu_a & alu_b;
         3'b011:  alu_out = alu_a;
         3'b100:  alu_out = alu_a | alu_b;
         3'b101:  alu_out = alu_a ^ alu_b;
         default: alu_out = alu_b;
      endcase
      alu_z = (alu_out == 16'h0);
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic load(input logic [2:0] a, input logic [15:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld_en = 1'b0;
   endtask

   // Issue from IDLE; return EXEC operands and wb_done per cycle (0=accept..3=write).
   task automatic issue(input logic [2:0] op, ra, rb, rd,
                        output logic [15:0] ea, eb, output logic [2:0] es,
                        output logic [3:0] wbm, output logic rdy);
      instr_valid = 1'b1; instr_op = op; instr_ra = ra; instr_rb = rb; instr_rd = rd;
      #1; rdy = instr_ready; wbm[0] = wb_done;
      @(posedge clk); #1; instr_valid = 1'b0; wbm[1] = wb_done;
      tick(); ea = alu_a; eb = alu_b; es = alu_select; wbm[2] = wb_done;
      tick(); wbm[3] = wb_done;
      tick();
   endtask

   task automatic read_reg(input logic [2:0] r, output logic [15:0] v);
      logic [15:0] eb; logic [2:0] es; logic [3:0] wbm; logic rdy;
      issue(3'b011, r, 3'd0, r, v, eb, es, wbm, rdy);
   endtask

   task automatic do_reset();
      reset = 1'b1; tick(); tick(); reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] v;
      do_reset();
      tests++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", instr_ready); end
      tests++; if ({halted, wb_done, z_reg} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {halted, wb_done, z_reg}); end
      tests++; if ({alu_a, alu_b, alu_select} !== 35'h0) begin fails++; $display("FAIL reset_alu_regs got %h/%h/%h want 0", alu_a, alu_b, alu_select); end
      read_reg(3'd3, v);
      tests++; if (v !== 16'h0) begin fails++; $display("FAIL reset_r3 got %h want 0000", v); end
   endtask

   task automatic test_add();
      logic [15:0] ea, eb, v; logic [2:0] es; logic [3:0] wbm; logic rdy;
      load(3'd1, 16'd5); load(3'd2, 16'd3);
      issue(3'b000, 3'd1, 3'd2, 3'd3, ea, eb, es, wbm, rdy);
      tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL add_ready got %b want 1", rdy); end
      tests++; if ({ea, eb} !== {16'd5, 16'd3}) begin fails++; $display("FAIL add_operands got %0d/%0d want 5/3", ea, eb); end
      tests++; if (es !== 3'b000) begin fails++; $display("FAIL add_select got %b want 000", es); end
      tests++; if (wbm !== 4'b1000) begin fails++; $display("FAIL add_wb_latency got %b want 1000", wbm); end
      tests++; if (z_reg !== 1'b0) begin fails++; $display("FAIL add_z got %b want 0", z_reg); end
      read_reg(3'd3, v);
      tests++; if (v !== 16'd8) begin fails++; $display("FAIL add_r3 got %0d want 8", v); end
   endtask

   task automatic test_sub_zero();
      logic [15:0] ea, eb, v; logic [2:0] es; logic [3:0] wbm; logic rdy;
      load(3'd1, 16'd7); load(3'd2, 16'd7);
      issue(3'b001, 3'd1, 3'd2, 3'd4, ea, eb, es, wbm, rdy);
      tests++; if (z_reg !== 1'b1) begin fails++; $display("FAIL sub_z got %b want 1", z_reg); end
      read_reg(3'd4, v);
      tests++; if (v !== 16'd0) begin fails++; $display("FAIL sub_r4 got %0d want 0", v); end
      issue(3'b011, 3'd1, 3'd0, 3'd5, ea, eb, es, wbm, rdy);
      tests++; if (z_reg !== 1'b1) begin fails++; $display("FAIL pass_z_kept got %b want 1", z_reg); end
      read_reg(3'd5, v);
      tests++; if (v !== 16'd7) begin fails++; $display("FAIL pass_r5 got %0d want 7", v); end
   endtask

   task automatic test_truncate_and_alias();
      logic [15:0] ea, eb, v; logic [2:0] es; logic [3:0] wbm; logic rdy;
      load(3'd1, 16'hFFFF); load(3'd2, 16'h0002);
      issue(3'b000, 3'd1, 3'd2, 3'd6, ea, eb, es, wbm, rdy);
      tests++; if (z_reg !== 1'b0) begin fails++; $display("FAIL trunc_z got %b want 0", z_reg); end
      read_reg(3'd6, v);
      tests++; if (v !== 16'h0001) begin fails++; $display("FAIL trunc_r6 got %h want 0001", v); end
      // source equals destination: operands are the pre-write value
      load(3'd1, 16'd5);
      issue(3'b000, 3'd1, 3'd1, 3'd1, ea, eb, es, wbm, rdy);
      tests++; if ({ea, eb} !== {16'd5, 16'd5}) begin fails++; $display("FAIL alias_operands got %0d/%0d want 5/5", ea, eb); end
      read_reg(3'd1, v);
      tests++; if (v !== 16'd10) begin fails++; $display("FAIL alias_r1 got %0d want 10", v); end
   endtask

   task automatic test_ld_priority();
      logic [15:0] v; logic [15:0] ea;
      instr_valid = 1'b1; instr_op = 3'b011; instr_ra = 3'd7; instr_rb = 3'd0; instr_rd = 3'd2;
      ld_en = 1'b1; ld_addr = 3'd7; ld_data = 16'h1234;
      #1;
      tests++; if (instr_ready !== 1'b0) begin fails++; $display("FAIL ldpri_ready_low got %b want 0", instr_ready); end
      @(posedge clk); #1; ld_en = 1'b0; #1;
      tests++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL ldpri_ready_next got %b want 1", instr_ready); end
      @(posedge clk); #1; instr_valid = 1'b0;
      tick(); ea = alu_a;
      tests++; if (ea !== 16'h1234) begin fails++; $display("FAIL ldpri_exec_a got %h want 1234", ea); end
      tick();
      tests++; if (wb_done !== 1'b1) begin fails++; $display("FAIL ldpri_wb got %b want 1", wb_done); end
      tick();
      read_reg(3'd2, v);
      tests++; if (v !== 16'h1234) begin fails++; $display("FAIL ldpri_r2 got %h want 1234", v); end
   endtask

   task automatic test_ld_ignored_busy();
      logic [15:0] v;
      load(3'd1, 16'h0011);
      instr_valid = 1'b1; instr_op = 3'b011; instr_ra = 3'd1; instr_rb = 3'd0; instr_rd = 3'd6;
      @(posedge clk); #1; instr_valid = 1'b0;
      ld_en = 1'b1; ld_addr = 3'd1; ld_data = 16'hAAAA;
      tick(); tick(); tick();
      ld_en = 1'b0;
      read_reg(3'd1, v);
      tests++; if (v !== 16'h0011) begin fails++; $display("FAIL ld_busy_r1 got %h want 0011", v); end
   endtask

   task automatic test_reset_mid_exec();
      logic [15:0] v;
      load(3'd3, 16'h0055);
      instr_valid = 1'b1; instr_op = 3'b000; instr_ra = 3'd1; instr_rb = 3'd2; instr_rd = 3'd3;
      @(posedge clk); #1; instr_valid = 1'b0;
      tick();
      reset = 1'b1; #1;
      tests++; if (wb_done !== 1'b0) begin fails++; $display("FAIL rstexec_wb_now got %b want 0", wb_done); end
      @(posedge clk); #1; reset = 1'b0; #1;
      tests++; if (wb_done !== 1'b0) begin fails++; $display("FAIL rstexec_wb_next got %b want 0", wb_done); end
      tests++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL rstexec_idle got %b want 1", instr_ready); end
      @(posedge clk); #1;
      read_reg(3'd3, v);
      tests++; if (v !== 16'h0) begin fails++; $display("FAIL rstexec_r3 got %h want 0000", v); end
   endtask

   task automatic test_halt();
      instr_valid = 1'b1; instr_op = 3'b110; instr_ra = 3'd1; instr_rb = 3'd2; instr_rd = 3'd3;
      @(posedge clk); #1; instr_valid = 1'b0;
      tick();
      tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_exec got %b want 0", halted); end
      tick();
      tests++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_entered got %b want 1", halted); end
      instr_valid = 1'b1; ld_en = 1'b1; ld_addr = 3'd1; ld_data = 16'h0077;
      for (int i = 0; i < 10; i++) begin
         #1;
         tests++;
         if ({instr_ready, wb_done, halted} !== 3'b001) begin
            fails++; $display("FAIL halt_hold cyc %0d got rdy/wb/halt %b want 001", i, {instr_ready, wb_done, halted});
         end
         @(posedge clk);
      end
      #1; instr_valid = 1'b0; ld_en = 1'b0;
      reset = 1'b1; tick(); reset = 1'b0; #1;
      tests++; if ({halted, instr_ready} !== 2'b01) begin fails++; $display("FAIL halt_reset got halt/rdy %b want 01", {halted, instr_ready}); end
      @(posedge clk); #1;
   endtask

   task automatic test_r0();
      logic [15:0] ea, eb, v, want; logic [2:0] es; logic [3:0] wbm; logic rdy;
`ifdef OPSTAGE_R0_ZERO_EN
      want = 16'd0;
`else
      want = 16'd9;
`endif
      load(3'd1, 16'h00F0);
      load(3'd0, 16'd9);
      issue(3'b011, 3'd0, 3'd0, 3'd1, ea, eb, es, wbm, rdy);
      tests++; if (wbm[3] !== 1'b1) begin fails++; $display("FAIL r0_wb got %b want 1", wbm[3]); end
      read_reg(3'd1, v);
      tests++; if (v !== want) begin fails++; $display("FAIL r0_r1 got %0d want %0d", v, want); end
   endtask

   initial begin
      reset = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_ra = '0; instr_rb = '0; instr_rd = '0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      test_reset();
      test_add();
      test_sub_zero();
      test_truncate_and_alias();
      test_ld_priority();
      test_ld_ignored_busy();
      test_reset_mid_exec();
      test_halt();
      test_r0();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter DATA_LEN, default 16, SHALL set the operand, result and register width.
REQ-002 Parameter ALU_SIG_LEN, default 3, SHALL set the ALU select width.
REQ-003 Parameter REG_ADDR_LEN, default 3, SHALL size the register bank at 2**REG_ADDR_LEN entries.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on posedge.
REQ-005 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-006 instr_valid  in  1  SHALL flag that an instruction is offered.
REQ-007 instr_ready  out  1  SHALL flag that an offered instruction is accepted this cycle.
REQ-008 instr_op  in  ALU_SIG_LEN  SHALL carry the ALU operation code.
REQ-009 instr_ra, instr_rb, instr_rd  in  REG_ADDR_LEN each  SHALL carry the source A, source B and destination register indices.
REQ-010 ld_en  in  1; ld_addr  in  REG_ADDR_LEN; ld_data  in  DATA_LEN  SHALL form the direct register-load port.
REQ-011 alu_a, alu_b  out  DATA_LEN  SHALL drive the ALU operands from registers.
REQ-012 alu_select  out  ALU_SIG_LEN  SHALL drive the ALU select from a register.
REQ-013 alu_out  in  DATA_LEN; alu_z  in  1  SHALL return the ALU result and zero flag.
REQ-014 z_reg  out  1  SHALL hold the last captured zero flag.
REQ-015 wb_done  out  1  SHALL pulse for one cycle when a result is written back.
REQ-016 halted  out  1  SHALL be high while the HALT state is active.

Function
REQ-017 States SHALL be IDLE, FETCH, EXEC, WRITE, HALT.
REQ-018 instr_ready SHALL equal (state==IDLE && !ld_en); an instruction is accepted when instr_valid && instr_ready.
REQ-019 On acceptance, op/ra/rb/rd SHALL be latched and the state SHALL go to FETCH.
REQ-020 FETCH SHALL register alu_a=reg[ra], alu_b=reg[rb], alu_select=op, then go to EXEC.
REQ-021 EXEC SHALL be a one-cycle settle of the combinational ALU, then go to WRITE, except op 110, which SHALL go to HALT with no write.
REQ-022 WRITE SHALL store alu_out into reg[rd], assert wb_done for that cycle, and return to IDLE; accept-to-wb_done latency SHALL be 3 cycles.
REQ-023 z_reg SHALL load alu_z in WRITE only for ops 000 and 001; other ops leave it unchanged.
REQ-024 Writes SHALL be truncated to DATA_LEN bits; no overflow flag.
REQ-025 ld_en SHALL write ld_data to reg[ld_addr] only in IDLE; in other states it SHALL be ignored.
REQ-026 ld_en and instr_valid together in IDLE: load performed, instruction not accepted.
REQ-027 ra==rd or rb==rd SHALL read the pre-write value; no bypass is needed.
REQ-028 HALT SHALL hold until reset; instr_ready low, ld_en ignored, halted high.

Reset
REQ-029 On reset: state IDLE; alu_a, alu_b, alu_select, z_reg, wb_done, halted all 0; every register entry 0.
REQ-030 Reset asserted in any state, including mid-operation or HALT, SHALL abort it with no write-back on that or the following cycle.

Configuration
REQ-031 Macro OPSTAGE_R0_ZERO_EN defined: entry 0 SHALL always read 0, with instruction and ld_en writes to it discarded; wb_done still pulses.
REQ-032 OPSTAGE_R0_ZERO_EN undefined: entry 0 SHALL be an ordinary register.

Verification
REQ-033 Load r1=5, r2=3, issue op 000 ra=1 rb=2 rd=3 -> alu_a=5, alu_b=3 in EXEC; r3=8, z_reg=0, wb_done 3 cycles after accept.
REQ-034 Load r1=7, r2=7, issue op 001 rd=4 -> r4=0, z_reg=1; next op 011 ra=1 rd=5 -> r5=7, z_reg stays 1.
REQ-035 Issue op 110 -> halted=1 from the cycle after EXEC, instr_ready=0 for 10 cycles, no wb_done; reset -> IDLE, halted=0.
REQ-036 ld_en and instr_valid high together in IDLE -> load done, instr_ready=0; instruction accepted the next cycle once ld_en drops.
REQ-037 Reset pulsed during EXEC of op 000 rd=3 -> r3=0, no wb_done, state IDLE.
REQ-038 With OPSTAGE_R0_ZERO_EN: load r0=9, op 011 ra=0 rd=1 -> r1=0; without it -> r1=9.
